// File: rtl/instr_encoder_pkg.sv
// Shared encoder constants: request format codes, RV32I major opcodes, FSM states.
package instr_encoder_pkg;

  localparam logic [3:0] ENC_R      = 4'd0;
  localparam logic [3:0] ENC_ICOMP  = 4'd1;
  localparam logic [3:0] ENC_LOAD   = 4'd2;
  localparam logic [3:0] ENC_STORE  = 4'd3;
  localparam logic [3:0] ENC_BRANCH = 4'd4;
  localparam logic [3:0] ENC_JAL    = 4'd5;
  localparam logic [3:0] ENC_JALR   = 4'd6;
  localparam logic [3:0] ENC_LUI    = 4'd7;
  localparam logic [3:0] ENC_AUIPC  = 4'd8;
  localparam logic [3:0] ENC_CSR    = 4'd9;
  localparam logic [3:0] ENC_LI     = 4'd10;

  localparam logic [6:0] R_FORMAT       = 7'b0110011;
  localparam logic [6:0] I_COMP_FORMAT  = 7'b0010011;
  localparam logic [6:0] I_LOAD_FORMAT  = 7'b0000011;
  localparam logic [6:0] S_FORMAT       = 7'b0100011;
  localparam logic [6:0] B_FORMAT       = 7'b1100011;
  localparam logic [6:0] J_FORMAT       = 7'b1101111;
  localparam logic [6:0] I_JALR_FORMAT  = 7'b1100111;
  localparam logic [6:0] U_FORMAT_LUI   = 7'b0110111;
  localparam logic [6:0] U_FORMAT_AUIPC = 7'b0010111;
  localparam logic [6:0] I_ENV_FORMAT   = 7'b1110011;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_LI_LO = 1'b1
  } encState_e;

  // True when v is representable as a 12-bit signed immediate.
  function automatic logic fitsSigned12(input logic [31:0] v);
    return (v[31:11] == '0) || (&v[31:11]);
  endfunction

endpackage

// File: rtl/instr_imm_pack.sv
// Places the request immediate into its RV32I bit positions and range-checks it.
module instr_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] immBits,
  output logic        inRange
);

  // Per-format scatter of immediate bits; unknown formats are out of range.
  always_comb begin
    immBits = '0;
    inRange = 1'b0;
    case (fmt)
      ENC_R, ENC_LI: begin
        inRange = 1'b1;
      end
      ENC_ICOMP, ENC_LOAD, ENC_JALR: begin
        immBits = {imm[11:0], 20'b0};
        inRange = fitsSigned12(imm);
      end
      ENC_CSR: begin
        immBits = {imm[11:0], 20'b0};
        inRange = 1'b1;
      end
      ENC_STORE: begin
        immBits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        inRange = fitsSigned12(imm);
      end
      ENC_BRANCH: begin
        immBits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        inRange = ((imm[31:12] == '0) || (&imm[31:12])) && !imm[0];
      end
      ENC_JAL: begin
        immBits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        inRange = ((imm[31:20] == '0) || (&imm[31:20])) && !imm[0];
      end
      ENC_LUI, ENC_AUIPC: begin
        immBits = {imm[19:0], 12'b0};
        inRange = 1'b1;
      end
      default: begin
        immBits = '0;
        inRange = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Field-level request to RV32I instruction word encoder with LI expansion.
//
// state   | meaning
// S_IDLE  | accepting requests; output register holds zero or one word
// S_LI_LO | LUI of a split LI on the output; ADDI waiting in pendQ
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_fmt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic [31:0]      req_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             instr_last,
  output logic             enc_err,
  output logic [CNT_W-1:0] instr_count
);

  encState_e   stateQ, stateD;
  logic [31:0] immBits;
  logic        inRange;
  logic [31:0] baseWord, pendWord, pendQ, pendD, instrD;
  logic        lastFlag, splitLi, validD, lastD, errD;
  logic [19:0] liHi;
  logic        accept, outHs;

  instr_imm_pack uImmPack (
    .fmt     (req_fmt),
    .imm     (req_imm),
    .immBits (immBits),
    .inRange (inRange)
  );

  assign req_ready = (stateQ == S_IDLE) && (!instr_valid || instr_ready);
  assign accept    = req_valid && req_ready;
  assign outHs     = instr_valid && instr_ready;
  // Rounded upper part so that LUI + sign-extended low 12 bits rebuilds req_imm.
  assign liHi      = req_imm[31:12] + {19'b0, req_imm[11]};

  // Assemble the first word of the request and, for split LI, the follow-up ADDI.
  always_comb begin
    baseWord = '0;
    pendWord = '0;
    lastFlag = 1'b1;
    splitLi  = 1'b0;
    case (req_fmt)
      ENC_R:      baseWord = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, R_FORMAT};
      ENC_ICOMP:  baseWord = immBits | {12'b0, req_rs1, req_funct3, req_rd, I_COMP_FORMAT};
      ENC_LOAD:   baseWord = immBits | {12'b0, req_rs1, req_funct3, req_rd, I_LOAD_FORMAT};
      ENC_JALR:   baseWord = immBits | {12'b0, req_rs1, req_funct3, req_rd, I_JALR_FORMAT};
      ENC_CSR:    baseWord = immBits | {12'b0, req_rs1, req_funct3, req_rd, I_ENV_FORMAT};
      ENC_STORE:  baseWord = immBits | {7'b0, req_rs2, req_rs1, req_funct3, 5'b0, S_FORMAT};
      ENC_BRANCH: baseWord = immBits | {7'b0, req_rs2, req_rs1, req_funct3, 5'b0, B_FORMAT};
      ENC_JAL:    baseWord = immBits | {20'b0, req_rd, J_FORMAT};
      ENC_LUI:    baseWord = immBits | {20'b0, req_rd, U_FORMAT_LUI};
      ENC_AUIPC:  baseWord = immBits | {20'b0, req_rd, U_FORMAT_AUIPC};
      ENC_LI: begin
        if (fitsSigned12(req_imm)) begin
          baseWord = {req_imm[11:0], 5'd0, 3'b000, req_rd, I_COMP_FORMAT};
        end else begin
          baseWord = {liHi, req_rd, U_FORMAT_LUI};
          splitLi  = (req_imm[11:0] != 12'h000);
          lastFlag = !splitLi;
          pendWord = {req_imm[11:0], req_rd, 3'b000, req_rd, I_COMP_FORMAT};
        end
      end
      default: baseWord = '0;
    endcase
  end

  // Next state and next output-register contents.
  always_comb begin
    stateD = stateQ;
    instrD = instr;
    validD = instr_valid && !outHs;
    lastD  = instr_last;
    errD   = 1'b0;
    pendD  = pendQ;
    if ((stateQ == S_LI_LO) && outHs) begin
      instrD = pendQ;
      validD = 1'b1;
      lastD  = 1'b1;
      stateD = S_IDLE;
    end
    if (accept) begin
      if (!inRange) begin
        errD = 1'b1;
      end else begin
        instrD = baseWord;
        validD = 1'b1;
        lastD  = lastFlag;
        if (splitLi) begin
          pendD  = pendWord;
          stateD = S_LI_LO;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) stateQ <= S_IDLE;
    else        stateQ <= stateD;
  end

  // Output register, pending ADDI and handshake counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_last  <= 1'b0;
      enc_err     <= 1'b0;
      pendQ       <= '0;
      instr_count <= '0;
    end else begin
      instr       <= instrD;
      instr_valid <= validD;
      instr_last  <= lastD;
      enc_err     <= errD;
      pendQ       <= pendD;
      if (outHs) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed table, corner sequences, random vs model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [3:0]       req_fmt;
  logic [4:0]       req_rd, req_rs1, req_rs2;
  logic [2:0]       req_funct3;
  logic [6:0]       req_funct7;
  logic [31:0]      req_imm;
  logic             instr_valid, instr_ready;
  logic [31:0]      instr;
  logic             instr_last, enc_err;
  logic [CNT_W-1:0] instr_count;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_last(instr_last), .enc_err(enc_err), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        err;
    logic [31:0] w0;
    logic        l0;
    logic        two;
    logic [31:0] w1;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } word_t;

  vec_t  tbl[$];
  word_t expQ[$];
  logic  expErr;
  logic [CNT_W-1:0] modelCount;

  function automatic vec_t mk(input logic [3:0] fmt, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                              input logic err, input logic [31:0] w0, input logic l0,
                              input logic two, input logic [31:0] w1);
    vec_t v;
    v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm;
    v.err = err; v.w0 = w0; v.l0 = l0; v.two = two; v.w1 = w1;
    return v;
  endfunction

  // Reference encoder: range rules as signed arithmetic, fields placed by shift/mask.
  function automatic void model(input logic [3:0] fmt, input logic [4:0] rd, rs1, rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                output logic err, output int n, output logic [31:0] w0,
                                output logic l0, output logic [31:0] w1);
    longint s = longint'($signed(imm));
    longint lo;
    logic [31:0] hi;
    logic [31:0] rdF  = 32'(rd) << 7;
    logic [31:0] rs1F = 32'(rs1) << 15;
    logic [31:0] rs2F = 32'(rs2) << 20;
    logic [31:0] f3F  = 32'(f3) << 12;
    logic [31:0] iImm = (imm & 32'hFFF) << 20;
    bit iOk = (s >= -2048) && (s <= 2047);
    err = 1'b0; n = 1; l0 = 1'b1; w0 = '0; w1 = '0;
    case (fmt)
      ENC_R:      w0 = (32'(f7) << 25) | rs2F | rs1F | f3F | rdF | 32'h33;
      ENC_ICOMP:  begin err = !iOk; w0 = iImm | rs1F | f3F | rdF | 32'h13; end
      ENC_LOAD:   begin err = !iOk; w0 = iImm | rs1F | f3F | rdF | 32'h03; end
      ENC_JALR:   begin err = !iOk; w0 = iImm | rs1F | f3F | rdF | 32'h67; end
      ENC_CSR:    w0 = iImm | rs1F | f3F | rdF | 32'h73;
      ENC_STORE:  begin
        err = !iOk;
        w0 = (((imm >> 5) & 32'h7F) << 25) | rs2F | rs1F | f3F | ((imm & 32'h1F) << 7) | 32'h23;
      end
      ENC_BRANCH: begin
        err = !((s >= -4096) && (s <= 4094) && (imm[0] == 1'b0));
        w0 = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | rs2F | rs1F | f3F |
             (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      end
      ENC_JAL: begin
        err = !((s >= -1048576) && (s <= 1048574) && (imm[0] == 1'b0));
        w0 = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rdF | 32'h6F;
      end
      ENC_LUI:    w0 = ((imm & 32'hFFFFF) << 12) | rdF | 32'h37;
      ENC_AUIPC:  w0 = ((imm & 32'hFFFFF) << 12) | rdF | 32'h17;
      ENC_LI: begin
        if (iOk) begin
          w0 = iImm | rdF | 32'h13;
        end else begin
          lo = ((s & 64'hFFF) ^ 64'h800) - 64'h800;
          hi = 32'((s - lo) >>> 12) & 32'hFFFFF;
          w0 = (hi << 12) | rdF | 32'h37;
          if (lo != 0) begin
            n = 2; l0 = 1'b0;
            w1 = ((32'(lo) & 32'hFFF) << 20) | (32'(rd) << 15) | rdF | 32'h13;
          end
        end
      end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic setReq(input vec_t v);
    req_fmt = v.fmt; req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2;
    req_funct3 = v.f3; req_funct7 = v.f7; req_imm = v.imm;
  endtask

  task automatic doReset();
    reset = 1'b0;
    req_valid = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    expQ.delete();
    expErr = 1'b0;
    modelCount = '0;
  endtask

  // One negedge-aligned cycle per iteration: compare against model, then drive next inputs.
  task automatic runCycles(input int cycles, input bit randomReq);
    logic [31:0] corner [14];
    vec_t v;
    logic mErr, mL0, hs, acc;
    int mN;
    logic [31:0] mW0, mW1;
    corner = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFE, 32'h1000, 32'hFFFFF000,
               32'hFFFFEFFE, 32'hFFFFE, 32'h100000, 32'hFFF00000, 32'hFFEFFFFE, 32'h1, 32'hFFFFFFFF};
    for (int c = 0; c < cycles; c++) begin
      check("enc_err", enc_err, expErr);
      check("instr_count", instr_count, modelCount);
      check("instr_valid", instr_valid, expQ.size() != 0);
      if (expQ.size() != 0) begin
        check("instr", instr, expQ[0].w);
        check("instr_last", instr_last, expQ[0].last);
      end
      if (randomReq) begin
        req_valid   = ($urandom_range(0, 3) != 0);
        instr_ready = ($urandom_range(0, 3) != 0);
        v.fmt = 4'($urandom_range(0, 11));
        if (v.fmt == 4'd11) v.fmt = 4'($urandom_range(11, 15));
        v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        case ($urandom_range(0, 4))
          0: v.imm = $urandom_range(0, 8191) - 32'd4096;
          1: v.imm = $urandom;
          2: v.imm = $urandom & 32'hFFFFF000;
          3: v.imm = corner[$urandom_range(0, 13)];
          default: v.imm = $urandom_range(0, 32'h3FFFFF) - 32'h200000;
        endcase
        setReq(v);
      end else begin
        req_valid = 1'b0;
        instr_ready = 1'b1;
      end
      #1;
      check("req_ready", req_ready, (expQ.size() < 2) && (expQ.size() == 0 || instr_ready));
      hs  = instr_valid && instr_ready;
      acc = req_valid && req_ready;
      expErr = 1'b0;
      if (hs) begin
        if (expQ.size() != 0) void'(expQ.pop_front());
        modelCount++;
      end
      if (acc) begin
        model(req_fmt, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
              mErr, mN, mW0, mL0, mW1);
        if (mErr) expErr = 1'b1;
        else begin
          expQ.push_back('{w: mW0, last: mL0});
          if (mN == 2) expQ.push_back('{w: mW1, last: 1'b1});
        end
      end
      @(negedge clock);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [CNT_W-1:0] expCount;

    req_fmt = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    req_funct3 = '0; req_funct7 = '0; req_imm = '0;
    doReset();
    check("rst instr_valid", instr_valid, 1'b0);
    check("rst instr", instr, 32'h0);
    check("rst instr_last", instr_last, 1'b0);
    check("rst enc_err", enc_err, 1'b0);
    check("rst instr_count", instr_count, 0);
    check("rst req_ready", req_ready, 1'b1);

    // fmt rd rs1 rs2 f3 f7 imm | err w0 last two w1
    tbl.push_back(mk(ENC_R,      3, 1, 2, 0, 0, 32'h0,        0, 32'h002081B3, 1, 0, 0));
    tbl.push_back(mk(ENC_LI,     5, 0, 0, 0, 0, 32'h12345678, 0, 32'h123452B7, 0, 1, 32'h67828293));
    tbl.push_back(mk(ENC_LI,     5, 0, 0, 0, 0, 32'h800,      0, 32'h000012B7, 0, 1, 32'h80028293));
    tbl.push_back(mk(ENC_LI,     5, 0, 0, 0, 0, 32'h1000,     0, 32'h000012B7, 1, 0, 0));
    tbl.push_back(mk(ENC_LI,     5, 0, 0, 0, 0, 32'hFFFFFFFB, 0, 32'hFFB00293, 1, 0, 0));
    tbl.push_back(mk(ENC_BRANCH, 0, 1, 2, 0, 0, 32'h8,        0, 32'h00208463, 1, 0, 0));
    tbl.push_back(mk(ENC_BRANCH, 0, 1, 2, 0, 0, 32'h3,        1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(ENC_BRANCH, 0, 1, 2, 0, 0, 32'hFFFFF000, 0, 32'h80208063, 1, 0, 0));
    tbl.push_back(mk(ENC_BRANCH, 0, 1, 2, 0, 0, 32'hFFE,      0, 32'h7E208FE3, 1, 0, 0));
    tbl.push_back(mk(ENC_BRANCH, 0, 1, 2, 0, 0, 32'h1000,     1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(ENC_ICOMP,  1, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 32'hFFF00093, 1, 0, 0));
    tbl.push_back(mk(ENC_ICOMP,  1, 0, 0, 0, 0, 32'h7FF,      0, 32'h7FF00093, 1, 0, 0));
    tbl.push_back(mk(ENC_ICOMP,  1, 0, 0, 0, 0, 32'hFFFFF800, 0, 32'h80000093, 1, 0, 0));
    tbl.push_back(mk(ENC_ICOMP,  1, 0, 0, 0, 0, 32'h800,      1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(ENC_ICOMP,  1, 0, 0, 0, 0, 32'hFFFFF7FF, 1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(ENC_LOAD,   2, 1, 0, 2, 0, 32'h4,        0, 32'h0040A103, 1, 0, 0));
    tbl.push_back(mk(ENC_STORE,  0, 1, 2, 2, 0, 32'h8,        0, 32'h0020A423, 1, 0, 0));
    tbl.push_back(mk(ENC_JAL,    1, 0, 0, 0, 0, 32'h8,        0, 32'h008000EF, 1, 0, 0));
    tbl.push_back(mk(ENC_JAL,    0, 0, 0, 0, 0, 32'h000FFFFE, 0, 32'h7FFFF06F, 1, 0, 0));
    tbl.push_back(mk(ENC_JAL,    0, 0, 0, 0, 0, 32'h00100000, 1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(ENC_JAL,    1, 0, 0, 0, 0, 32'h1,        1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(ENC_JALR,   1, 2, 0, 0, 0, 32'h4,        0, 32'h004100E7, 1, 0, 0));
    tbl.push_back(mk(ENC_CSR,    1, 2, 0, 1, 0, 32'h300,      0, 32'h300110F3, 1, 0, 0));
    tbl.push_back(mk(ENC_LUI,    5, 0, 0, 0, 0, 32'h12345,    0, 32'h123452B7, 1, 0, 0));
    tbl.push_back(mk(ENC_AUIPC,  1, 0, 0, 0, 0, 32'hFFFFF,    0, 32'hFFFFF097, 1, 0, 0));
    tbl.push_back(mk(4'hF,       1, 1, 1, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0));

    expCount = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      setReq(v);
      req_valid = 1'b1;
      instr_ready = 1'b1;
      #1 check("tbl req_ready", req_ready, 1'b1);
      @(negedge clock);
      req_valid = 1'b0;
      if (v.err) begin
        check("tbl enc_err", enc_err, 1'b1);
        check("tbl no word", instr_valid, 1'b0);
      end else begin
        check("tbl enc_err", enc_err, 1'b0);
        check("tbl valid0", instr_valid, 1'b1);
        check("tbl word0", instr, v.w0);
        check("tbl last0", instr_last, v.l0);
        expCount++;
        if (v.two) begin
          @(negedge clock);
          check("tbl valid1", instr_valid, 1'b1);
          check("tbl word1", instr, v.w1);
          check("tbl last1", instr_last, 1'b1);
          expCount++;
        end
      end
      @(negedge clock);
      check("tbl idle valid", instr_valid, 1'b0);
      check("tbl err pulse", enc_err, 1'b0);
      check("tbl count", instr_count, expCount);
    end

    // LI split with downstream stalled for three cycles.
    doReset();
    setReq(mk(ENC_LI, 5, 0, 0, 0, 0, 32'h12345678, 0, 0, 0, 0, 0));
    req_valid = 1'b1;
    instr_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall lui valid", instr_valid, 1'b1);
      check("stall lui word", instr, 32'h123452B7);
      check("stall lui last", instr_last, 1'b0);
      check("stall req_ready", req_ready, 1'b0);
      @(negedge clock);
    end
    instr_ready = 1'b1;
    #1 check("stall lo req_ready", req_ready, 1'b0);
    @(negedge clock);
    check("stall addi valid", instr_valid, 1'b1);
    check("stall addi word", instr, 32'h67828293);
    check("stall addi last", instr_last, 1'b1);
    @(negedge clock);
    check("stall done valid", instr_valid, 1'b0);
    check("stall count", instr_count, 2);

    // Reset while the ADDI half is still pending.
    doReset();
    setReq(mk(ENC_LI, 5, 0, 0, 0, 0, 32'h12345678, 0, 0, 0, 0, 0));
    req_valid = 1'b1;
    instr_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    check("rstlo lui word", instr, 32'h123452B7);
    reset = 1'b0;
    instr_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    check("rstlo valid", instr_valid, 1'b0);
    check("rstlo req_ready", req_ready, 1'b1);
    check("rstlo count", instr_count, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("rstlo no addi", instr_valid, 1'b0);
      check("rstlo count hold", instr_count, 0);
    end

    // Four back-to-back R requests.
    doReset();
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      setReq(mk(ENC_R, 5'(k + 1), 1, 2, 0, 0, 32'h0, 0, 0, 0, 0, 0));
      req_valid = 1'b1;
      #1 check("b2b req_ready", req_ready, 1'b1);
      if (k > 0) begin
        check("b2b valid", instr_valid, 1'b1);
        check("b2b word", instr, 32'h00208033 | (32'(k) << 7));
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    check("b2b valid last", instr_valid, 1'b1);
    check("b2b word last", instr, 32'h00208033 | (32'd4 << 7));
    @(negedge clock);
    check("b2b idle", instr_valid, 1'b0);
    check("b2b count", instr_count, 4);

    // Randomized traffic against the reference model, then drain.
    doReset();
    runCycles(3000, 1'b1);
    runCycles(8, 1'b0);
    check("drain empty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
